// File: rtl/bcd_updown_counter_n_if.sv
// Control and status bundle for the multi-digit BCD up/down counter.
// The master drives the count controls; the slave returns the registered count and flags.
interface bcd_updown_counter_n_if #(
   parameter int DIGITS = 4
);
   logic                  en;
   logic                  dir;
   logic                  load;
   logic [4*DIGITS-1:0]   load_val;
   logic [4*DIGITS-1:0]   bcd;
   logic                  cout;
   logic                  err;

   modport master (
      output en, dir, load, load_val,
      input  bcd, cout, err
   );

   modport slave (
      input  en, dir, load, load_val,
      output bcd, cout, err
   );
endinterface

// File: rtl/bcd_updown_counter_n.sv
// Cascaded DIGITS-digit BCD up/down counter with load, invalid-digit recovery,
// optional end-of-range saturation and registered terminal-count / error flags.
module bcd_updown_counter_n #(
   parameter int DIGITS   = 4,
   parameter bit SATURATE = 1'b0
) (
   input  logic                  clk,
   input  logic                  reset,
   bcd_updown_counter_n_if.slave bus
);
   localparam int           W     = 4 * DIGITS;
   localparam logic [W-1:0] NINES = {DIGITS{4'h9}};

   logic [W-1:0] bcd_q, bcd_d;
   logic         cout_q, cout_d;
   logic         err_q, err_d;

   logic [W-1:0] inc_val, dec_val;
   logic         any_invalid, all_nines, all_zeros;

   // Ripple carry/borrow across digits; a digit at 9 (up) or 0 (down) wraps and passes it on.
   always_comb begin : digit_arith
      logic       carry;
      logic       borrow;
      logic [3:0] dg;
      carry       = 1'b1;
      borrow      = 1'b1;
      any_invalid = 1'b0;
      all_nines   = 1'b1;
      all_zeros   = 1'b1;
      inc_val     = '0;
      dec_val     = '0;
      dg          = '0;
      for (int i = 0; i < DIGITS; i++) begin
         dg = bcd_q[4*i +: 4];
         if (dg > 4'd9) any_invalid = 1'b1;
         if (dg != 4'd9) all_nines = 1'b0;
         if (dg != 4'd0) all_zeros = 1'b0;
         if (carry) begin
            if (dg == 4'd9) begin
               inc_val[4*i +: 4] = 4'd0;
            end else begin
               inc_val[4*i +: 4] = dg + 4'd1;
               carry             = 1'b0;
            end
         end else begin
            inc_val[4*i +: 4] = dg;
         end
         if (borrow) begin
            if (dg == 4'd0) begin
               dec_val[4*i +: 4] = 4'd9;
            end else begin
               dec_val[4*i +: 4] = dg - 4'd1;
               borrow            = 1'b0;
            end
         end else begin
            dec_val[4*i +: 4] = dg;
         end
      end
   end

   // NOTE: every output of a combinational block gets a default first so no path infers a latch.
   always_comb begin : next_state
      bcd_d  = bcd_q;
      cout_d = 1'b0;
      err_d  = 1'b0;
      if (bus.load) begin
         bcd_d = bus.load_val;
      end else if (bus.en) begin
         if (any_invalid) begin
            bcd_d = '0;
            err_d = 1'b1;
         end else if (bus.dir) begin
            bcd_d  = (SATURATE && all_nines) ? bcd_q : inc_val;
            cout_d = (bcd_d == NINES);
         end else begin
            bcd_d  = (SATURATE && all_zeros) ? bcd_q : dec_val;
            cout_d = (bcd_d == '0);
         end
      end
   end

   // NOTE: state registers use non-blocking assignments so all flops sample the same pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         bcd_q  <= '0;
         cout_q <= 1'b0;
         err_q  <= 1'b0;
      end else begin
         bcd_q  <= bcd_d;
         cout_q <= cout_d;
         err_q  <= err_d;
      end
   end

   assign bus.bcd  = bcd_q;
   assign bus.cout = cout_q;
   assign bus.err  = err_q;
endmodule

// File: tb/tb_bcd_updown_counter_n.sv
// Directed bench: 4-digit wrapping, 4-digit saturating and 1-digit legacy counters
// driven with hand-computed vectors, sampled 1 ns after each rising edge.
module tb_bcd_updown_counter_n;
   logic clk;
   logic reset;
   int   n_checks;
   int   n_errors;

   bcd_updown_counter_n_if #(.DIGITS(4)) if_wrap ();
   bcd_updown_counter_n_if #(.DIGITS(4)) if_sat ();
   bcd_updown_counter_n_if #(.DIGITS(1)) if_leg ();

   bcd_updown_counter_n #(.DIGITS(4), .SATURATE(1'b0)) u_wrap (
      .clk(clk), .reset(reset), .bus(if_wrap)
   );
   bcd_updown_counter_n #(.DIGITS(4), .SATURATE(1'b1)) u_sat (
      .clk(clk), .reset(reset), .bus(if_sat)
   );
   bcd_updown_counter_n #(.DIGITS(1), .SATURATE(1'b0)) u_leg (
      .clk(clk), .reset(reset), .bus(if_leg)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_wrap(input string tag, input logic [15:0] b, input logic c, input logic e);
      check({tag, ".bcd"},  {16'h0, if_wrap.bcd}, {16'h0, b});
      check({tag, ".cout"}, {31'h0, if_wrap.cout}, {31'h0, c});
      check({tag, ".err"},  {31'h0, if_wrap.err},  {31'h0, e});
   endtask

   task automatic chk_sat(input string tag, input logic [15:0] b, input logic c, input logic e);
      check({tag, ".bcd"},  {16'h0, if_sat.bcd}, {16'h0, b});
      check({tag, ".cout"}, {31'h0, if_sat.cout}, {31'h0, c});
      check({tag, ".err"},  {31'h0, if_sat.err},  {31'h0, e});
   endtask

   task automatic chk_leg(input string tag, input logic [3:0] b, input logic c, input logic e);
      check({tag, ".bcd"},  {28'h0, if_leg.bcd}, {28'h0, b});
      check({tag, ".cout"}, {31'h0, if_leg.cout}, {31'h0, c});
      check({tag, ".err"},  {31'h0, if_leg.err},  {31'h0, e});
   endtask

   initial begin
      int prev;
      int exp_v;
      n_checks = 0;
      n_errors = 0;
      reset    = 1'b1;
      if_wrap.en = 1'b1; if_wrap.dir = 1'b1; if_wrap.load = 1'b1; if_wrap.load_val = 16'h1234;
      if_sat.en  = 1'b1; if_sat.dir  = 1'b1; if_sat.load  = 1'b1; if_sat.load_val  = 16'h5678;
      if_leg.en  = 1'b1; if_leg.dir  = 1'b1; if_leg.load  = 1'b1; if_leg.load_val  = 4'h7;

      // Reset overrides simultaneous load and en on every edge.
      for (int i = 0; i < 3; i++) begin
         tick();
         chk_wrap("rst_wrap", 16'h0000, 1'b0, 1'b0);
         chk_sat("rst_sat", 16'h0000, 1'b0, 1'b0);
         chk_leg("rst_leg", 4'h0, 1'b0, 1'b0);
      end
      reset = 1'b0;
      if_wrap.en = 1'b0; if_wrap.load = 1'b0;
      if_sat.en  = 1'b0; if_sat.load  = 1'b0;
      if_leg.en  = 1'b0; if_leg.load  = 1'b0;

      // Ripple carry through several digits.
      if_wrap.load = 1'b1; if_wrap.load_val = 16'h0998;
      tick(); chk_wrap("ld0998", 16'h0998, 1'b0, 1'b0);
      if_wrap.load = 1'b0; if_wrap.en = 1'b1; if_wrap.dir = 1'b1;
      tick(); chk_wrap("up0999", 16'h0999, 1'b0, 1'b0);
      tick(); chk_wrap("up1000", 16'h1000, 1'b0, 1'b0);

      // Load beats en; dir ignored on a load cycle.
      if_wrap.load = 1'b1; if_wrap.load_val = 16'h9998; if_wrap.dir = 1'b0;
      tick(); chk_wrap("ld9998", 16'h9998, 1'b0, 1'b0);
      if_wrap.load = 1'b0; if_wrap.dir = 1'b1;
      tick(); chk_wrap("up9999", 16'h9999, 1'b1, 1'b0);
      tick(); chk_wrap("wrap_up", 16'h0000, 1'b0, 1'b0);

      if_wrap.load = 1'b1; if_wrap.load_val = 16'h0001;
      tick(); chk_wrap("ld0001", 16'h0001, 1'b0, 1'b0);
      if_wrap.load = 1'b0; if_wrap.dir = 1'b0;
      tick(); chk_wrap("dn0000", 16'h0000, 1'b1, 1'b0);
      tick(); chk_wrap("wrap_dn", 16'h9999, 1'b0, 1'b0);
      // Direction change takes effect on the same cycle.
      if_wrap.dir = 1'b1;
      tick(); chk_wrap("dirflip", 16'h0000, 1'b0, 1'b0);
      if_wrap.dir = 1'b0;
      tick(); chk_wrap("dirback", 16'h9999, 1'b0, 1'b0);

      // Invalid digit: clear, flag once, then normal counting.
      if_wrap.load = 1'b1; if_wrap.load_val = 16'h12A4;
      tick(); chk_wrap("ld12A4", 16'h12A4, 1'b0, 1'b0);
      if_wrap.load = 1'b0; if_wrap.dir = 1'b1;
      tick(); chk_wrap("invalid", 16'h0000, 1'b0, 1'b1);
      tick(); chk_wrap("recover", 16'h0001, 1'b0, 1'b0);

      // Hold for 5 edges.
      if_wrap.en = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick(); chk_wrap("hold", 16'h0001, 1'b0, 1'b0);
      end

      // cout drops on a hold after reaching the terminal value.
      if_wrap.load = 1'b1; if_wrap.load_val = 16'h9998;
      tick();
      if_wrap.load = 1'b0; if_wrap.en = 1'b1;
      tick(); chk_wrap("term", 16'h9999, 1'b1, 1'b0);
      if_wrap.en = 1'b0;
      tick(); chk_wrap("term_hold", 16'h9999, 1'b0, 1'b0);

      // Reset mid-count.
      if_wrap.load = 1'b1; if_wrap.load_val = 16'h0457;
      tick();
      if_wrap.load = 1'b0; if_wrap.en = 1'b1;
      tick(); chk_wrap("pre_rst", 16'h0458, 1'b0, 1'b0);
      reset = 1'b1;
      tick(); chk_wrap("mid_rst", 16'h0000, 1'b0, 1'b0);
      reset = 1'b0; if_wrap.en = 1'b0;

      // Saturating instance holds at both ends with cout held high.
      if_sat.load = 1'b1; if_sat.load_val = 16'h9999;
      tick(); chk_sat("sat_ld", 16'h9999, 1'b0, 1'b0);
      if_sat.load = 1'b0; if_sat.en = 1'b1; if_sat.dir = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick(); chk_sat("sat_up", 16'h9999, 1'b1, 1'b0);
      end
      if_sat.dir = 1'b0;
      tick(); chk_sat("sat_dn", 16'h9998, 1'b0, 1'b0);
      if_sat.load = 1'b1; if_sat.load_val = 16'h0001;
      tick();
      if_sat.load = 1'b0;
      tick(); chk_sat("sat_zero", 16'h0000, 1'b1, 1'b0);
      tick(); chk_sat("sat_zhold", 16'h0000, 1'b1, 1'b0);
      if_sat.dir = 1'b1;
      tick(); chk_sat("sat_leave", 16'h0001, 1'b0, 1'b0);
      if_sat.en = 1'b0;

      // Legacy single digit: each edge compared with a successor of the previous value.
      if_leg.load = 1'b1; if_leg.load_val = 4'h8;
      tick(); chk_leg("leg_ld", 4'h8, 1'b0, 1'b0);
      prev = 8;
      if_leg.load = 1'b0; if_leg.en = 1'b1; if_leg.dir = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         exp_v = (prev == 9) ? 0 : prev + 1;
         chk_leg("leg_up", 4'(exp_v), exp_v == 9, 1'b0);
         prev = exp_v;
      end
      if_leg.dir = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         exp_v = (prev == 0) ? 9 : prev - 1;
         chk_leg("leg_dn", 4'(exp_v), exp_v == 0, 1'b0);
         prev = exp_v;
      end
      if_leg.load = 1'b1; if_leg.load_val = 4'hC;
      tick(); chk_leg("leg_ldC", 4'hC, 1'b0, 1'b0);
      if_leg.load = 1'b0;
      tick(); chk_leg("leg_inv", 4'h0, 1'b0, 1'b1);
      tick(); chk_leg("leg_after", 4'h9, 1'b0, 1'b0);
      if_leg.en = 1'b0;

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end
endmodule
